// File: rtl/dc_ipu_filter_phase_scheduler.sv
// Bicubic filter phase scheduler.
// Walks the destination raster of one frame and emits one beat per output
// pixel: the integer source anchor plus the top fraction bits of each axis
// position, which index the weight LUTs.
// Optional feature macro: DC_IPU_FILTER_CENTER_ALIGN_EN (pixel-center-aligned
// start positions instead of corner-aligned).
//
// state | meaning
// IDLE  | waiting for cfg_start; no beat presented
// RUN   | a beat is presented on out_*; advances on out_ready
// DONE  | one-cycle frame-complete pulse, then back to IDLE
module dc_ipu_filter_phase_scheduler #(
    parameter int COORD_WIDTH = 12,
    parameter int FRACT_WIDTH = 16,
    parameter int PHASE_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clr,
    input  logic                               cfg_start,
    input  logic [COORD_WIDTH-1:0]             cfg_dst_width,
    input  logic [COORD_WIDTH-1:0]             cfg_dst_height,
    input  logic [COORD_WIDTH+FRACT_WIDTH-1:0] cfg_step_x,
    input  logic [COORD_WIDTH+FRACT_WIDTH-1:0] cfg_step_y,
    output logic                               busy,
    output logic                               done,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COORD_WIDTH-1:0]             out_src_x,
    output logic [COORD_WIDTH-1:0]             out_src_y,
    output logic [PHASE_WIDTH-1:0]             out_phase_x,
    output logic [PHASE_WIDTH-1:0]             out_phase_y,
    output logic                               out_last_x,
    output logic                               out_last_y
);

    localparam int POS_WIDTH = COORD_WIDTH + FRACT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [COORD_WIDTH-1:0] width_q, height_q;
    logic [COORD_WIDTH-1:0] dx, dy;
    logic [POS_WIDTH-1:0]   step_x_q, step_y_q;
    logic [POS_WIDTH-1:0]   init_x_q, init_y_q;
    logic [POS_WIDTH-1:0]   pos_x, pos_y;
    logic                   last_x_q, last_y_q;
    logic [POS_WIDTH-1:0]   init_x_calc, init_y_calc;

    logic latch_cfg;
    logic dims_ok;
    logic accept;

`ifdef DC_IPU_FILTER_CENTER_ALIGN_EN
    // Start half a step in, minus half a source pixel; clamp at zero for
    // upscaling ratios where that would go negative.
    function automatic logic [POS_WIDTH-1:0] center_init(input logic [POS_WIDTH-1:0] step);
        logic [POS_WIDTH-1:0] half_step;
        logic [POS_WIDTH-1:0] half_pixel;
        half_step  = step >> 1;
        half_pixel = POS_WIDTH'(1) << (FRACT_WIDTH - 1);
        return (half_step > half_pixel) ? (half_step - half_pixel) : '0;
    endfunction

    assign init_x_calc = center_init(cfg_step_x);
    assign init_y_calc = center_init(cfg_step_y);
`else
    assign init_x_calc = '0;
    assign init_y_calc = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus the start/accept strobes used by the datapath.
    always_comb begin
        state_next = state;
        dims_ok    = (cfg_dst_width != '0) && (cfg_dst_height != '0);
        latch_cfg  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    latch_cfg  = 1'b1;
                    state_next = dims_ok ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                accept = out_ready;
                if (out_ready && last_x_q && last_y_q) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (clr) begin
            state_next = ST_IDLE;
            latch_cfg  = 1'b0;
            accept     = 1'b0;
        end
    end

    // Raster counters, position accumulators and latched configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_q  <= '0;
            height_q <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            init_x_q <= '0;
            init_y_q <= '0;
            dx       <= '0;
            dy       <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            last_x_q <= 1'b0;
            last_y_q <= 1'b0;
        end else if (clr) begin
            width_q  <= '0;
            height_q <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            init_x_q <= '0;
            init_y_q <= '0;
            dx       <= '0;
            dy       <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            last_x_q <= 1'b0;
            last_y_q <= 1'b0;
        end else if (latch_cfg) begin
            width_q  <= cfg_dst_width;
            height_q <= cfg_dst_height;
            step_x_q <= cfg_step_x;
            step_y_q <= cfg_step_y;
            init_x_q <= init_x_calc;
            init_y_q <= init_y_calc;
            dx       <= '0;
            dy       <= '0;
            pos_x    <= init_x_calc;
            pos_y    <= init_y_calc;
            last_x_q <= (cfg_dst_width == COORD_WIDTH'(1));
            last_y_q <= (cfg_dst_height == COORD_WIDTH'(1));
        end else if (accept) begin
            if (last_x_q) begin
                // End of line: rewind x, step down one output line.
                dx       <= '0;
                pos_x    <= init_x_q;
                dy       <= dy + COORD_WIDTH'(1);
                pos_y    <= pos_y + step_y_q;
                last_x_q <= (width_q == COORD_WIDTH'(1));
                last_y_q <= ((dy + COORD_WIDTH'(1)) == (height_q - COORD_WIDTH'(1)));
            end else begin
                dx       <= dx + COORD_WIDTH'(1);
                pos_x    <= pos_x + step_x_q;
                last_x_q <= ((dx + COORD_WIDTH'(1)) == (width_q - COORD_WIDTH'(1)));
            end
        end
    end

    // A beat is presented for exactly as long as the FSM sits in RUN.
    assign busy        = (state == ST_RUN);
    assign out_valid   = (state == ST_RUN);
    assign done        = (state == ST_DONE);
    assign out_src_x   = pos_x[POS_WIDTH-1:FRACT_WIDTH];
    assign out_src_y   = pos_y[POS_WIDTH-1:FRACT_WIDTH];
    assign out_phase_x = pos_x[FRACT_WIDTH-1 -: PHASE_WIDTH];
    assign out_phase_y = pos_y[FRACT_WIDTH-1 -: PHASE_WIDTH];
    assign out_last_x  = last_x_q;
    assign out_last_y  = last_y_q;

endmodule

// File: doc/dc_ipu_filter_phase_scheduler.md
Name: dc_ipu_filter_phase_scheduler

Overview:
Sequences the bicubic filter datapath for one frame of scaled output. It walks the destination raster and accumulates fixed-point source positions with per-axis step values. For each output pixel it emits one beat: the source window anchor (integer part) and the x/y phase indices (top fraction bits). The texel fetch unit and the weight LUTs consume these beats, and the LUTs feed weights_x/weights_y to the outer-product stage.

Parameters:
COORD_WIDTH, 12, bit width of integer source/destination coordinates
FRACT_WIDTH, 16, fractional bits of the position accumulators and step values
PHASE_WIDTH, 5, phase index bits taken from the top of the fraction (2^PHASE_WIDTH LUT entries)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
clr  in  1  synchronous clear; same effect as reset, but clocked
cfg_start  in  1  start-of-frame pulse; sampled only in IDLE
cfg_dst_width  in  COORD_WIDTH  output pixels per line
cfg_dst_height  in  COORD_WIDTH  output lines per frame
cfg_step_x  in  COORD_WIDTH+FRACT_WIDTH  unsigned source increment per output pixel
cfg_step_y  in  COORD_WIDTH+FRACT_WIDTH  unsigned source increment per output line
busy  out  1  high in RUN
done  out  1  one-cycle pulse at frame completion
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_src_x  out  COORD_WIDTH  integer part of pos_x
out_src_y  out  COORD_WIDTH  integer part of pos_y
out_phase_x  out  PHASE_WIDTH  pos_x[FRACT_WIDTH-1 -: PHASE_WIDTH]
out_phase_y  out  PHASE_WIDTH  pos_y[FRACT_WIDTH-1 -: PHASE_WIDTH]
out_last_x  out  1  beat is the last of a line
out_last_y  out  1  beat is on the last line of the frame

Behaviour:
- Reset: state=IDLE; all outputs 0; accumulators and counters 0; latched config 0.
- States:
  - IDLE -> RUN on cfg_start when width!=0 and height!=0. All cfg_* are latched in that cycle.
  - IDLE -> DONE on cfg_start when either dimension is 0. No beats are emitted.
  - RUN -> DONE when the last beat (out_last_x && out_last_y) is accepted.
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only while in DONE.
- cfg_start in RUN or DONE is ignored. cfg_* changes after latching have no effect.
- Latency: cfg_start accepted in cycle N -> out_valid=1 in cycle N+1 with beat (0,0), pos_x=pos_y=init.
- Beat outputs are registered. While out_valid && !out_ready, every out_* stays stable. out_valid does not drop until the beat is accepted.
- On acceptance (out_valid && out_ready):
  - Not end of line: dx++, pos_x += step_x.
  - End of line (dx==width-1): dx=0, pos_x=init_x, dy++, pos_y += step_y.
  - Next beat is presented in the following cycle, giving 1 beat/cycle throughput with out_ready held high.
- Accumulators are COORD_WIDTH+FRACT_WIDTH bits, unsigned, and wrap modulo 2^(COORD_WIDTH+FRACT_WIDTH). Overflow is a config error and is not detected.
- out_last_x = (dx==width-1). out_last_y = (dy==height-1). Both are registered alongside the beat.
- clr or reset mid-frame: return to IDLE immediately (reset asynchronously, clr at the next edge), out_valid=0, no done pulse. The partial frame is abandoned.
- clr takes priority over cfg_start in the same cycle.

Optional Feature:
Macro DC_IPU_FILTER_CENTER_ALIGN_EN.
- Defined: init_x = max(step_x/2 - 0.5, 0) in fixed point, computed at latch time. init_y uses the same rule. This gives pixel-center-aligned scaling; when the subtraction goes negative, the result is clamped to 0.
- Undefined: init_x = init_y = 0 (corner-aligned).
- The beat sequence and handshake are otherwise identical.

Test Plan:
- Basic raster, feature off: width=4, height=2, step_x=0x08000 (0.5), step_y=0x10000, out_ready=1. Expect 8 consecutive beats:
  - x=0,0,1,1 with phase_x=0,16,0,16, repeated for each line.
  - y=0 then 1, phase_y=0.
  - last_x on beats 3 and 7; last_y on beats 4-7.
  - done pulses 1 cycle after beat 7 is accepted; busy falls with it.
- Backpressure: same config, out_ready=0 for 3 cycles at beat 2. Beat 2 is held stable for 4 cycles and no beat is lost or duplicated. Total frame takes 8 accepted beats.
- Restart guard and zero dimension:
  - cfg_start pulsed during RUN: no effect; the beat count stays 8.
  - cfg_start with width=0: no out_valid; done pulses in cycle N+1.
- Mid-frame abort: clr asserted after beat 3 is accepted. Next cycle: out_valid=0, busy=0, done never pulses. A fresh cfg_start then begins again at (0,0).
- Asynchronous reset during backpressure: out_valid drops in the same cycle without waiting for a clock edge. All outputs read 0.
- Feature on: step_x=0x20000 (2.0). init_x=0x08000, so x sequence is 0,2,4 with phase_x=16. With step_x=0x08000, the negative init clamps to 0 and the sequence matches the feature-off case.
